mem_port_arbiter: RTL and testbench

- Shares one single-port, variable-latency unified RAM between two requesters: instruction fetch (IF, read-only) and the load/store stage (MEM, read/write).
- Sits between the pipeline and the RAM model.
- Serialises accesses with an FSM, returns read data with a one-cycle valid pulse, and drives per-port busy flags that the pipeline hazard logic uses to freeze stages.
- A watchdog aborts accesses the RAM never acknowledges.

---
 rtl/mem_port_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port, variable-latency RAM between instruction fetch and load/store.
// Optional round-robin contention resolution: define MEM_PORT_ARB_RR_EN.
module mem_port_arbiter #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 9,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_busy,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_valid,
  output logic              mem_busy,
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ack,
  output logic              timeout_err
);

  // state   | meaning
  // IDLE    | no access in flight, arbitrate eligible requests
  // GNT_IF  | RAM granted to instruction fetch, waiting for ram_ack
  // GNT_MEM | RAM granted to load/store, waiting for ram_ack
  typedef enum logic [1:0] {IDLE, GNT_IF, GNT_MEM} state_t;

  localparam logic [7:0] TO_CNT = 8'(TIMEOUT_CYC);

  state_t            state_q, state_d;
  logic              ram_req_q, ram_req_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              if_valid_q, if_valid_d;
  logic              mem_valid_q, mem_valid_d;
  logic              timeout_err_q, timeout_err_d;
  logic [7:0]        wd_cnt_q, wd_cnt_d;
  logic              if_elig, mem_elig, mem_wins;

  // A port whose valid is high this cycle is about to drop req; do not serve it twice.
  assign if_elig  = if_req & ~if_valid_q;
  assign mem_elig = mem_req & ~mem_valid_q;

`ifdef MEM_PORT_ARB_RR_EN
  logic last_grant_q, last_grant_d;  // 1 = MEM was granted last

  assign mem_wins = ~last_grant_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) last_grant_q <= 1'b0;
    else        last_grant_q <= last_grant_d;
  end
`else
  assign mem_wins = 1'b1;
`endif

  always_comb begin
    state_d       = state_q;
    ram_req_d     = ram_req_q;
    ram_we_d      = ram_we_q;
    ram_addr_d    = ram_addr_q;
    ram_wdata_d   = ram_wdata_q;
    if_rdata_d    = if_rdata_q;
    mem_rdata_d   = mem_rdata_q;
    if_valid_d    = 1'b0;
    mem_valid_d   = 1'b0;
    timeout_err_d = timeout_err_q;
    wd_cnt_d      = wd_cnt_q;
`ifdef MEM_PORT_ARB_RR_EN
    last_grant_d  = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        if (mem_elig && (!if_elig || mem_wins)) begin
          state_d     = GNT_MEM;
          ram_req_d   = 1'b1;
          ram_we_d    = mem_we;
          ram_addr_d  = mem_addr;
          ram_wdata_d = mem_wdata;
          wd_cnt_d    = 8'd1;
`ifdef MEM_PORT_ARB_RR_EN
          last_grant_d = 1'b1;
`endif
        end else if (if_elig) begin
          state_d     = GNT_IF;
          ram_req_d   = 1'b1;
          ram_we_d    = 1'b0;
          ram_addr_d  = if_addr;
          ram_wdata_d = '0;
          wd_cnt_d    = 8'd1;
`ifdef MEM_PORT_ARB_RR_EN
          last_grant_d = 1'b0;
`endif
        end
      end
      GNT_IF, GNT_MEM: begin
        if (ram_ack) begin
          state_d   = IDLE;
          ram_req_d = 1'b0;
          wd_cnt_d  = '0;
          if (state_q == GNT_IF) begin
            if_valid_d = 1'b1;
            if_rdata_d = ram_rdata;
          end else begin
            mem_valid_d = 1'b1;
            if (!ram_we_q) mem_rdata_d = ram_rdata;
          end
        end else if (wd_cnt_q >= TO_CNT) begin
          // Ack on this same edge would have won above; this is a genuine abort.
          state_d       = IDLE;
          ram_req_d     = 1'b0;
          wd_cnt_d      = '0;
          timeout_err_d = 1'b1;
          if (state_q == GNT_IF) begin
            if_valid_d = 1'b1;
            if_rdata_d = '0;
          end else begin
            mem_valid_d = 1'b1;
            mem_rdata_d = '0;
          end
        end else begin
          wd_cnt_d = wd_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      ram_req_q     <= 1'b0;
      ram_we_q      <= 1'b0;
      ram_addr_q    <= '0;
      ram_wdata_q   <= '0;
      if_rdata_q    <= '0;
      mem_rdata_q   <= '0;
      if_valid_q    <= 1'b0;
      mem_valid_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      wd_cnt_q      <= '0;
    end else begin
      state_q       <= state_d;
      ram_req_q     <= ram_req_d;
      ram_we_q      <= ram_we_d;
      ram_addr_q    <= ram_addr_d;
      ram_wdata_q   <= ram_wdata_d;
      if_rdata_q    <= if_rdata_d;
      mem_rdata_q   <= mem_rdata_d;
      if_valid_q    <= if_valid_d;
      mem_valid_q   <= mem_valid_d;
      timeout_err_q <= timeout_err_d;
      wd_cnt_q      <= wd_cnt_d;
    end
  end

  assign if_rdata    = if_rdata_q;
  assign if_valid    = if_valid_q;
  assign if_busy     = if_req & ~if_valid_q;
  assign mem_rdata   = mem_rdata_q;
  assign mem_valid   = mem_valid_q;
  assign mem_busy    = mem_req & ~mem_valid_q;
  assign ram_req     = ram_req_q;
  assign ram_we      = ram_we_q;
  assign ram_addr    = ram_addr_q;
  assign ram_wdata   = ram_wdata_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requesters push expected read data, a monitor pops on valid.
// A behavioural RAM acks after a programmable number of granted cycles (0 = never).
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [8:0]  if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_valid, if_busy;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [8:0]  mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [31:0] mem_rdata;
  logic        mem_valid, mem_busy;
  logic        ram_req, ram_we;
  logic [8:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = '0;
  logic        ram_ack = 1'b0;
  logic        timeout_err;

  mem_port_arbiter #(.DATA_W(32), .ADDR_W(9), .TIMEOUT_CYC(15)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid), .if_busy(if_busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid), .mem_busy(mem_busy),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ack(ram_ack), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

`ifdef MEM_PORT_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  int n_total = 0;
  int n_pass  = 0;
  logic [31:0] if_q[$];
  logic [31:0] mem_q[$];

  logic [31:0] ram_mem [0:511];
  int          ack_at = 1;
  int          req_cyc = 0;
  int          max_cyc = 0;
  int          grants = 0;
  int          stable_err = 0;
  logic [8:0]  cap_addr = '0;
  logic        cap_we = 1'b0;
  logic [31:0] cap_wdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // RAM model: counts granted cycles, captures the request on the first one.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (ram_req) begin
        req_cyc++;
        if (req_cyc == 1) begin
          cap_addr = ram_addr; cap_we = ram_we; cap_wdata = ram_wdata; grants++;
        end else if (ram_addr !== cap_addr || ram_we !== cap_we || ram_wdata !== cap_wdata) begin
          stable_err++;
        end
        if (req_cyc > max_cyc) max_cyc = req_cyc;
        if (ack_at != 0 && req_cyc == ack_at) begin
          ram_ack = 1'b1;
          ram_rdata = ram_mem[ram_addr];
          if (ram_we) ram_mem[ram_addr] = ram_wdata;
        end else begin
          ram_ack = 1'b0;
          ram_rdata = 32'hBAD0BAD0;
        end
      end else begin
        req_cyc = 0;
        ram_ack = 1'b0;
        ram_rdata = 32'hBAD0BAD0;
      end
    end
  end

  // Monitor: every valid pulse must match the oldest expectation of that port.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        if (if_valid) begin
          if (if_q.size() == 0) chk("if_valid_unexpected", {31'b0, if_valid}, 32'd0);
          else chk("if_rdata", if_rdata, if_q.pop_front());
        end
        if (mem_valid) begin
          if (mem_q.size() == 0) chk("mem_valid_unexpected", {31'b0, mem_valid}, 32'd0);
          else chk("mem_rdata", mem_rdata, mem_q.pop_front());
        end
      end
    end
  end

  task automatic if_access(input logic [8:0] addr, input logic [31:0] exp, output int lat);
    bit got = 0;
    if_q.push_back(exp);
    if_addr = addr;
    if_req  = 1'b1;
    lat = 0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(posedge clk); #1;
      lat++;
      if (if_valid) got = 1;
    end
    if (!got) chk("if_valid_wait", {31'b0, if_valid}, 32'd1);
    else chk("if_busy_at_valid", {31'b0, if_busy}, 32'd0);
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  task automatic mem_access(input logic [8:0] addr, input logic we, input logic [31:0] wd,
                            input logic [31:0] exp, output int lat);
    bit got = 0;
    bit busy_ok = 1;
    mem_q.push_back(exp);
    mem_addr  = addr;
    mem_we    = we;
    mem_wdata = wd;
    mem_req   = 1'b1;
    lat = 0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(posedge clk); #1;
      lat++;
      if (mem_valid) got = 1;
      else if (!mem_busy) busy_ok = 0;
    end
    if (!got) chk("mem_valid_wait", {31'b0, mem_valid}, 32'd1);
    else begin
      chk("mem_busy_at_valid", {31'b0, mem_busy}, 32'd0);
      chk("mem_busy_before_valid", {31'b0, busy_ok}, 32'd1);
    end
    @(posedge clk); #1;
    mem_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int lat_if, lat_mem;
    for (int i = 0; i < 512; i++) ram_mem[i] = '0;
    ram_mem[9'h004] = 32'hDEADBEEF;
    ram_mem[9'h008] = 32'h11112222;
    ram_mem[9'h020] = 32'hCAFEF00D;
    ram_mem[9'h030] = 32'h0BADF00D;

    // Reset state
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ram_req", {31'b0, ram_req}, 32'd0);
    chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_mem_valid", {31'b0, mem_valid}, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_mem_rdata", mem_rdata, 32'd0);
    chk("rst_timeout_err", {31'b0, timeout_err}, 32'd0);
    chk("rst_ram_addr", {23'b0, ram_addr}, 32'd0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // IF read, ack in first granted cycle; idle MEM inputs must not leak into the grant
    mem_we = 1'b1; mem_wdata = 32'hA5A5A5A5; mem_addr = 9'h1FF;
    ack_at = 1; grants = 0;
    if_access(9'h004, 32'hDEADBEEF, lat_if);
    chk("if_read_latency", 32'(lat_if), 32'd2);
    chk("if_read_ram_addr", {23'b0, cap_addr}, 32'h004);
    chk("if_read_ram_we", {31'b0, cap_we}, 32'd0);
    chk("if_read_ram_wdata", cap_wdata, 32'd0);
    chk("if_read_grants", 32'(grants), 32'd1);

    // MEM read, ack in second granted cycle
    ack_at = 2;
    mem_access(9'h020, 1'b0, 32'h0, 32'hCAFEF00D, lat_mem);
    chk("mem_read_latency", 32'(lat_mem), 32'd3);

    // MEM write, 3-cycle ack; mem_rdata keeps the previous read value
    ack_at = 3; grants = 0; stable_err = 0;
    mem_access(9'h010, 1'b1, 32'h12345678, 32'hCAFEF00D, lat_mem);
    chk("mem_write_latency", 32'(lat_mem), 32'd4);
    chk("mem_write_ram_addr", {23'b0, cap_addr}, 32'h010);
    chk("mem_write_ram_we", {31'b0, cap_we}, 32'd1);
    chk("mem_write_ram_wdata", cap_wdata, 32'h12345678);
    chk("mem_write_stable", 32'(stable_err), 32'd0);
    chk("mem_write_grants", 32'(grants), 32'd1);

    // Contention, two rounds. The last grant so far was MEM, so round-robin favours IF.
    ack_at = 1;
    for (int r = 0; r < 2; r++) begin
      fork
        if_access(9'h008, 32'h11112222, lat_if);
        mem_access(9'h010, 1'b0, 32'h0, 32'h12345678, lat_mem);
      join
      chk("contend_if_latency", 32'(lat_if), RR ? 32'd2 : 32'd4);
      chk("contend_mem_latency", 32'(lat_mem), RR ? 32'd4 : 32'd2);
    end

    // Watchdog abort on the 15th granted cycle
    ack_at = 0; max_cyc = 0;
    mem_access(9'h030, 1'b0, 32'h0, 32'h0, lat_mem);
    chk("timeout_latency", 32'(lat_mem), 32'd16);
    chk("timeout_granted_cycles", 32'(max_cyc), 32'd15);
    chk("timeout_err_set", {31'b0, timeout_err}, 32'd1);
    ack_at = 1;
    if_access(9'h004, 32'hDEADBEEF, lat_if);
    chk("timeout_err_sticky", {31'b0, timeout_err}, 32'd1);

    // Reset mid-access while MEM is granted
    ack_at = 0;
    mem_we = 1'b0; mem_addr = 9'h030; mem_req = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    chk("midrst_ram_req_before", {31'b0, ram_req}, 32'd1);
    #3 reset = 1'b0;
    #1;
    chk("midrst_ram_req_dropped", {31'b0, ram_req}, 32'd0);
    chk("midrst_timeout_err", {31'b0, timeout_err}, 32'd0);
    mem_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("midrst_ram_req_after", {31'b0, ram_req}, 32'd0);
    chk("midrst_mem_rdata", mem_rdata, 32'd0);

    // Ack on exactly the timeout edge wins
    ack_at = 15;
    mem_access(9'h020, 1'b0, 32'h0, 32'hCAFEF00D, lat_mem);
    chk("ack_on_edge_latency", 32'(lat_mem), 32'd16);
    chk("ack_on_edge_no_err", {31'b0, timeout_err}, 32'd0);

    repeat (4) @(posedge clk);
    #1;
    chk("if_queue_drained", 32'(if_q.size()), 32'd0);
    chk("mem_queue_drained", 32'(mem_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
